// File: rtl/imem_fetch_arbiter.sv
// Purpose : shares one byte-wide instruction ROM port between CPU fetch (port 0) and debug (port 1).
// Latency : in-range word acked 5 cycles after the request is sampled; out-of-range word acked after 1.
// Backpr. : requests are held until ackN; a granted request cannot be aborted; the loser waits in IDLE.
//
// Ports:
//   clk, reset            single clock, asynchronous active-high reset
//   req0/addr0            port 0 (CPU fetch) request and byte address
//   ack0/rdata0/err0      port 0 one-cycle response; rdata0/err0 hold between acks
//   req1/addr1            port 1 (debug/dump) request and byte address
//   ack1/rdata1/err1      port 1 one-cycle response; rdata1/err1 hold between acks
//   rom_addr/rom_byte     byte-wide ROM read port (ROM answers combinationally)
//   busy                  high while a word is being read or answered
//   owner                 port currently granted; keeps its value while idle
module imem_fetch_arbiter #(
    parameter int ROM_BYTES = 256,
    parameter bit FIXED_PRI = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0,
    input  logic [31:0] addr0,
    output logic        ack0,
    output logic [31:0] rdata0,
    output logic        err0,
    input  logic        req1,
    input  logic [31:0] addr1,
    output logic        ack1,
    output logic [31:0] rdata1,
    output logic        err1,
    output logic [31:0] rom_addr,
    input  logic [7:0]  rom_byte,
    output logic        busy,
    output logic        owner
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state, state_nxt;
    logic [1:0]  cnt;
    logic [31:0] base;
    logic [31:0] word;
    logic        last_grant;

    logic        grant_vld;
    logic        grant_port;
    logic [31:0] grant_base;
    logic        grant_oor;
    logic [31:0] word_cap;

    // Arbitration and next-state decode.
    always_comb begin
        state_nxt  = state;
        grant_vld  = (state == IDLE) && (req0 || req1);
        grant_port = 1'b0;
        if (req0 && req1) begin
            // Round-robin hands the tie to whichever port did not win last time.
            grant_port = FIXED_PRI ? 1'b0 : ~last_grant;
        end else begin
            grant_port = req1;
        end
        // Masking keeps the full address in use while forcing word alignment.
        grant_base = (grant_port ? addr1 : addr0) & ~32'h3;
        grant_oor  = (grant_base >= 32'(ROM_BYTES));

        unique case (state)
            IDLE: begin
                if (grant_vld) begin
                    state_nxt = grant_oor ? RESP : READ;
                end
            end
            READ: begin
                if (cnt == 2'd3) begin
                    state_nxt = RESP;
                end
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Current word with this cycle's ROM byte merged into its little-endian lane.
    always_comb begin
        word_cap = word;
        word_cap[8*cnt +: 8] = rom_byte;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt        <= 2'd0;
            base       <= 32'd0;
            word       <= 32'd0;
            owner      <= 1'b0;
            last_grant <= 1'b1;
            rdata0     <= 32'd0;
            err0       <= 1'b0;
            rdata1     <= 32'd0;
            err1       <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (grant_vld) begin
                        owner <= grant_port;
                        base  <= grant_base;
                        cnt   <= 2'd0;
                        // Out-of-range words skip the ROM; the response is loaded now.
                        if (grant_oor) begin
                            if (grant_port) begin
                                rdata1 <= 32'd0;
                                err1   <= 1'b1;
                            end else begin
                                rdata0 <= 32'd0;
                                err0   <= 1'b1;
                            end
                        end
                    end
                end
                READ: begin
                    word <= word_cap;
                    cnt  <= cnt + 2'd1;
                    // Response registers load on the last byte so they are valid during RESP.
                    if (cnt == 2'd3) begin
                        if (owner) begin
                            rdata1 <= word_cap;
                            err1   <= 1'b0;
                        end else begin
                            rdata0 <= word_cap;
                            err0   <= 1'b0;
                        end
                    end
                end
                RESP: begin
                    last_grant <= owner;
                end
                default: begin
                    cnt <= 2'd0;
                end
            endcase
        end
    end

    assign ack0     = (state == RESP) && !owner;
    assign ack1     = (state == RESP) && owner;
    assign busy     = (state != IDLE);
    assign rom_addr = (state == READ) ? (base + {30'd0, cnt}) : 32'd0;

endmodule

// File: tb/tb_imem_fetch_arbiter.sv
// Purpose : self-checking bench for imem_fetch_arbiter (round-robin and fixed-priority instances).
// Latency : bench walks each transaction cycle by cycle against the expected ack cycle.
// Backpr. : requesters hold req until their ack; the model decides who is served next.
module tb_imem_fetch_arbiter;

    localparam bit [1:0] FIXED = 2'b10; // instance 0 round-robin, instance 1 fixed priority

    logic        clk;
    logic        reset;
    logic [1:0]  req0, req1, ack0, ack1, err0, err1, busy, owner;
    logic [31:0] addr0 [2];
    logic [31:0] addr1 [2];
    logic [31:0] rdata0 [2];
    logic [31:0] rdata1 [2];
    logic [31:0] rom_addr [2];
    logic [7:0]  rom_byte [2];
    logic [7:0]  rom [256];

    int n_pass  = 0;
    int n_total = 0;
    int lg [2];

    imem_fetch_arbiter #(.ROM_BYTES(256), .FIXED_PRI(1'b0)) u_rr (
        .clk(clk), .reset(reset),
        .req0(req0[0]), .addr0(addr0[0]), .ack0(ack0[0]), .rdata0(rdata0[0]), .err0(err0[0]),
        .req1(req1[0]), .addr1(addr1[0]), .ack1(ack1[0]), .rdata1(rdata1[0]), .err1(err1[0]),
        .rom_addr(rom_addr[0]), .rom_byte(rom_byte[0]), .busy(busy[0]), .owner(owner[0])
    );

    imem_fetch_arbiter #(.ROM_BYTES(256), .FIXED_PRI(1'b1)) u_fp (
        .clk(clk), .reset(reset),
        .req0(req0[1]), .addr0(addr0[1]), .ack0(ack0[1]), .rdata0(rdata0[1]), .err0(err0[1]),
        .req1(req1[1]), .addr1(addr1[1]), .ack1(ack1[1]), .rdata1(rdata1[1]), .err1(err1[1]),
        .rom_addr(rom_addr[1]), .rom_byte(rom_byte[1]), .busy(busy[1]), .owner(owner[1])
    );

    assign rom_byte[0] = (rom_addr[0] < 32'd256) ? rom[rom_addr[0][7:0]] : 8'h00;
    assign rom_byte[1] = (rom_addr[1] < 32'd256) ? rom[rom_addr[1][7:0]] : 8'h00;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h required %h", tag, obs, exp);
    endtask

    // Serve one word on instance d from the current request inputs (cycle 0 already set up).
    task automatic txn(input int d, input bit wobble);
        int          w;
        int          ib;
        int          lat;
        logic [31:0] b;
        logic        oor;
        logic [31:0] ew;
        if (req0[d] && req1[d]) w = FIXED[d] ? 0 : 1 - lg[d];
        else                    w = req1[d] ? 1 : 0;
        b   = (w == 1) ? addr1[d] : addr0[d];
        b   = {b[31:2], 2'b00};
        oor = (b >= 32'd256);
        ib  = int'(b[7:0]);
        ew  = oor ? 32'd0 : {rom[ib+3], rom[ib+2], rom[ib+1], rom[ib]};
        lat = oor ? 1 : 5;
        for (int k = 1; k <= lat; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (k < lat) begin
                chk($sformatf("d%0d read busy c%0d", d, k), 32'(busy[d]), 32'd1);
                chk($sformatf("d%0d read ack0 c%0d", d, k), 32'(ack0[d]), 32'd0);
                chk($sformatf("d%0d read ack1 c%0d", d, k), 32'(ack1[d]), 32'd0);
                chk($sformatf("d%0d rom_addr c%0d", d, k), rom_addr[d], b + 32'(k - 1));
                if (wobble && k == 2) begin
                    req0[d]  = 1'($urandom);
                    req1[d]  = 1'($urandom);
                    addr0[d] = $urandom;
                    addr1[d] = $urandom;
                end
            end else begin
                chk($sformatf("d%0d ack p%0d", d, w), 32'(w == 1 ? ack1[d] : ack0[d]), 32'd1);
                chk($sformatf("d%0d other ack", d), 32'(w == 1 ? ack0[d] : ack1[d]), 32'd0);
                chk($sformatf("d%0d rdata p%0d", d, w), (w == 1) ? rdata1[d] : rdata0[d], ew);
                chk($sformatf("d%0d err p%0d", d, w), 32'(w == 1 ? err1[d] : err0[d]), 32'(oor));
                chk($sformatf("d%0d owner", d), 32'(owner[d]), 32'(w));
                chk($sformatf("d%0d resp busy", d), 32'(busy[d]), 32'd1);
                chk($sformatf("d%0d resp rom_addr", d), rom_addr[d], 32'd0);
            end
        end
        lg[d] = w;
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) rom[i] = 8'($urandom);
        {rom[3],  rom[2],  rom[1],  rom[0]}  = 32'h201d00fc;
        {rom[7],  rom[6],  rom[5],  rom[4]}  = 32'hafbe0000;
        {rom[11], rom[10], rom[9],  rom[8]}  = 32'h23bdfffc;
        {rom[27], rom[26], rom[25], rom[24]} = 32'h0c00000c;

        reset = 1'b1;
        req0  = 2'b00;
        req1  = 2'b00;
        for (int d = 0; d < 2; d++) begin
            addr0[d] = 32'd0;
            addr1[d] = 32'd0;
            lg[d]    = 1;
        end
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // Idle after reset: everything quiet.
        repeat (10) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("d%0d rst ack0", d), 32'(ack0[d]), 32'd0);
            chk($sformatf("d%0d rst ack1", d), 32'(ack1[d]), 32'd0);
            chk($sformatf("d%0d rst rdata0", d), rdata0[d], 32'd0);
            chk($sformatf("d%0d rst rdata1", d), rdata1[d], 32'd0);
            chk($sformatf("d%0d rst err0", d), 32'(err0[d]), 32'd0);
            chk($sformatf("d%0d rst err1", d), 32'(err1[d]), 32'd0);
            chk($sformatf("d%0d rst busy", d), 32'(busy[d]), 32'd0);
            chk($sformatf("d%0d rst owner", d), 32'(owner[d]), 32'd0);
            chk($sformatf("d%0d rst rom_addr", d), rom_addr[d], 32'd0);
        end
        @(posedge clk);
        #1;

        // Port 0 fetch of word 0, then the response must hold while idle.
        req0[0] = 1'b1; addr0[0] = 32'h0;
        txn(0, 1'b0);
        req0[0] = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("hold rdata0", rdata0[0], 32'h201d00fc);
        chk("hold err0", 32'(err0[0]), 32'd0);
        chk("idle busy", 32'(busy[0]), 32'd0);
        @(posedge clk);
        #1;

        // Port 1 unaligned address.
        req1[0] = 1'b1; addr1[0] = 32'h1b;
        txn(0, 1'b0);
        req1[0] = 1'b0;
        @(negedge clk);
        chk("unaligned rdata1", rdata1[0], 32'h0c00000c);
        @(posedge clk);
        #1;

        // Contention, round-robin: alternates 0,1,0.
        req0[0] = 1'b1; addr0[0] = 32'h04;
        req1[0] = 1'b1; addr1[0] = 32'h08;
        repeat (3) txn(0, 1'b0);
        req0[0] = 1'b0; req1[0] = 1'b0;
        @(negedge clk);
        chk("rr rdata0", rdata0[0], 32'hafbe0000);
        chk("rr rdata1", rdata1[0], 32'h23bdfffc);
        @(posedge clk);
        #1;

        // Contention, fixed priority: port 1 never served.
        req0[1] = 1'b1; addr0[1] = 32'h04;
        req1[1] = 1'b1; addr1[1] = 32'h08;
        repeat (3) txn(1, 1'b0);
        req0[1] = 1'b0; req1[1] = 1'b0;
        @(negedge clk);
        chk("fp starved rdata1", rdata1[1], 32'd0);
        chk("fp rdata0", rdata0[1], 32'hafbe0000);
        @(posedge clk);
        #1;

        // Out-of-range word.
        req0[0] = 1'b1; addr0[0] = 32'h100;
        txn(0, 1'b0);
        req0[0] = 1'b0;
        @(negedge clk);
        chk("oor rdata0", rdata0[0], 32'd0);
        chk("oor err0", 32'(err0[0]), 32'd1);
        @(posedge clk);
        #1;

        // Reset in cycle 3 of a read: no ack, state cleared.
        req0[0] = 1'b1; addr0[0] = 32'h0;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        reset   = 1'b1;
        req0[0] = 1'b0;
        #2 reset = 1'b0;
        lg[0] = 1;
        lg[1] = 1;
        @(negedge clk);
        chk("midrst busy", 32'(busy[0]), 32'd0);
        chk("midrst rom_addr", rom_addr[0], 32'd0);
        chk("midrst err0", 32'(err0[0]), 32'd0);
        repeat (5) begin
            @(posedge clk);
            @(negedge clk);
            chk("midrst no ack0", 32'(ack0[0]), 32'd0);
        end
        @(posedge clk);
        #1;
        req0[0] = 1'b1; addr0[0] = 32'h0;
        txn(0, 1'b0);
        req0[0] = 1'b0;
        @(negedge clk);
        chk("post-rst rdata0", rdata0[0], 32'h201d00fc);
        @(posedge clk);
        #1;

        // Randomised traffic on both instances against the model.
        for (int i = 0; i < 80; i++) begin
            int          d;
            logic [1:0]  r;
            d = i % 2;
            r = 2'($urandom_range(1, 3));
            req0[d] = r[0];
            req1[d] = r[1];
            addr0[d] = ($urandom_range(0, 7) == 0) ? 32'h100 + 32'($urandom_range(0, 4000))
                                                   : 32'($urandom_range(0, 255));
            addr1[d] = ($urandom_range(0, 7) == 0) ? 32'h100 + 32'($urandom_range(0, 4000))
                                                   : 32'($urandom_range(0, 255));
            txn(d, 1'($urandom));
            req0[d] = 1'b0;
            req1[d] = 1'b0;
            if ($urandom_range(0, 2) == 0) begin
                @(posedge clk);
                #1;
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
